field_pair_tx: RTL and testbench

- Transmit-side counterpart of the field-select decoder. The decoder takes two 6-bit words x/y and extracts a 3-bit code: from x[5:3] inverted when x[5]==y[5], otherwise from y[2:0] inverted.
- This block accepts a 3-bit payload and a route flag over a valid/ready handshake. It builds the matching x/y word pair and shifts the 12-bit frame {x,y} out serially, MSB first.
- Sits between a payload producer and the serial link feeding the decoder side.

---
 rtl/field_pair_tx_if.sv | 30 +++
 rtl/field_pair_tx.sv | 147 ++++++++++++++
 tb/tb_field_pair_tx.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/field_pair_tx_if.sv
// -----------------------------------------------------------------------------
// field_pair_tx_if
// Purpose : valid/ready payload handshake between a payload producer and the
//           field_pair_tx serializer.
// Signals : in_valid   - producer has a payload
//           in_ready   - serializer can accept a payload
//           in_payload - 3-bit code the far-end decoder must recover
//           in_route   - 0: code carried in x field, 1: code carried in y field
// Modports: master (producer side), slave (serializer side)
// -----------------------------------------------------------------------------
interface field_pair_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_payload;
    logic       in_route;

    modport master (
        output in_valid,
        output in_payload,
        output in_route,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_payload,
        input  in_route,
        output in_ready
    );
endinterface

// File: rtl/field_pair_tx.sv
// -----------------------------------------------------------------------------
// field_pair_tx
// Purpose : accepts a 3-bit code plus route flag, builds the x/y word pair that
//           the field-select decoder maps back to the code, and shifts the
//           12-bit frame {x_word, y_word} out MSB first, each bit held for
//           BIT_CYCLES clocks.
// Ports   : clk     - system clock (rising edge)
//           rst_n   - asynchronous active-low reset
//           in_if   - payload handshake (slave modport)
//           x_word  - x word of current/last frame
//           y_word  - y word of current/last frame
//           sdo     - serial data out
//           sframe  - high while a frame bit is on sdo
//           done    - one-cycle pulse after the last frame bit
// All outputs are registered.
// -----------------------------------------------------------------------------
module field_pair_tx #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    field_pair_tx_if.slave in_if,
    output logic [5:0]     x_word,
    output logic [5:0]     y_word,
    output logic           sdo,
    output logic           sframe,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] CYC_LAST = 4'(BIT_CYCLES - 1);

    // route=0: sign bits equal, decoder reads ~x[5:3]; route=1: x is zero so
    // the signs differ and the decoder reads ~y[2:0].
    function automatic logic [5:0] build_x(input logic [2:0] p, input logic route);
        build_x = route ? 6'b000000 : {~p, 3'b000};
    endfunction

    function automatic logic [5:0] build_y(input logic [2:0] p, input logic route);
        build_y = route ? {1'b1, 2'b00, ~p} : {~p[2], 5'b00000};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [11:0] sr_q, sr_d;
    logic [3:0]  bit_q, bit_d;
    logic [3:0]  cyc_q, cyc_d;
    logic        sdo_q, sdo_d;
    logic        sframe_q, sframe_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        accept_s;

    assign accept_s       = in_if.in_valid & ready_q;
    assign in_if.in_ready = ready_q;
    assign x_word         = x_q;
    assign y_word         = y_q;
    assign sdo            = sdo_q;
    assign sframe         = sframe_q;
    assign done           = done_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    x_d     = build_x(in_if.in_payload, in_if.in_route);
                    y_d     = build_y(in_if.in_payload, in_if.in_route);
                    sr_d    = {build_x(in_if.in_payload, in_if.in_route),
                               build_y(in_if.in_payload, in_if.in_route)};
                    bit_d   = 4'd11;
                    cyc_d   = 4'd0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = 4'd0;
                    // Bit 0 finishing ends the frame; the index never wraps.
                    if (bit_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        sr_d  = {sr_q[10:0], 1'b0};
                        bit_d = bit_q - 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so that, once registered,
        // they line up exactly with the state they describe.
        sframe_d = (state_d == SHIFT);
        sdo_d    = (state_d == SHIFT) ? sr_d[11] : 1'b0;
        done_d   = (state_d == DONE);
        ready_d  = (state_d == IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= 6'd0;
            y_q      <= 6'd0;
            sr_q     <= 12'd0;
            bit_q    <= 4'd0;
            cyc_q    <= 4'd0;
            sdo_q    <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            sdo_q    <= sdo_d;
            sframe_q <= sframe_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

endmodule

// File: tb/tb_field_pair_tx.sv
// -----------------------------------------------------------------------------
// tb_field_pair_tx
// Directed self-checking bench for field_pair_tx. Two instances are used:
// dut_a with BIT_CYCLES=1 and dut_b with BIT_CYCLES=3. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_field_pair_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    field_pair_tx_if if_a ();
    field_pair_tx_if if_b ();

    logic [5:0] x_a, y_a, x_b, y_b;
    logic       sdo_a, sframe_a, done_a;
    logic       sdo_b, sframe_b, done_b;

    int checks = 0;
    int errors = 0;

    field_pair_tx #(.BIT_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_if(if_a.slave),
        .x_word(x_a), .y_word(y_a), .sdo(sdo_a), .sframe(sframe_a), .done(done_a)
    );

    field_pair_tx #(.BIT_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_if(if_b.slave),
        .x_word(x_b), .y_word(y_b), .sdo(sdo_b), .sframe(sframe_b), .done(done_b)
    );

    function automatic logic rdy(input int w);
        return (w == 0) ? if_a.in_ready : if_b.in_ready;
    endfunction
    function automatic logic sdo_of(input int w);
        return (w == 0) ? sdo_a : sdo_b;
    endfunction
    function automatic logic sframe_of(input int w);
        return (w == 0) ? sframe_a : sframe_b;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 0) ? done_a : done_b;
    endfunction
    function automatic logic [5:0] xw_of(input int w);
        return (w == 0) ? x_a : x_b;
    endfunction
    function automatic logic [5:0] yw_of(input int w);
        return (w == 0) ? y_a : y_b;
    endfunction

    // Far-end field-select decoder model.
    function automatic logic [2:0] decode(input logic [11:0] frame);
        logic [5:0] xs;
        logic [5:0] ys;
        xs = frame[11:6];
        ys = frame[5:0];
        return (xs[5] == ys[5]) ? ~xs[5:3] : ~ys[2:0];
    endfunction

    task automatic drive(input int w, input logic v, input logic r, input logic [2:0] p);
        if (w == 0) begin
            if_a.in_valid = v; if_a.in_route = r; if_a.in_payload = p;
        end else begin
            if_b.in_valid = v; if_b.in_route = r; if_b.in_payload = p;
        end
    endtask

    // Sends one payload and collects the frame. Entered and left at a falling
    // edge; on exit the DUT is in its first IDLE cycle after DONE.
    task automatic send_frame(input int w, input logic route, input logic [2:0] p,
                              input bit hold, output logic [11:0] stream,
                              output logic [5:0] xw, output logic [5:0] yw,
                              output int waited);
        int bc;
        bc = (w == 0) ? 1 : 3;
        stream = 12'd0;
        drive(w, 1'b1, route, p);
        waited = 0;
        while (!rdy(w) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (rdy(w) !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout dut=%0d in_ready=%b required 1", w, rdy(w));
        end
        @(negedge clk);
        // Scramble inputs while busy: they must not be sampled.
        drive(w, hold ? 1'b1 : 1'b0, ~route, ~p);
        xw = xw_of(w);
        yw = yw_of(w);
        for (int b = 11; b >= 0; b--) begin
            for (int c = 0; c < bc; c++) begin
                checks++;
                if (sframe_of(w) !== 1'b1 || rdy(w) !== 1'b0 || done_of(w) !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_ctrl dut=%0d bit=%0d sframe=%b in_ready=%b done=%b required 1/0/0",
                             w, b, sframe_of(w), rdy(w), done_of(w));
                end
                if (c == 0) begin
                    stream[b] = sdo_of(w);
                end else begin
                    checks++;
                    if (sdo_of(w) !== stream[b]) begin
                        errors++;
                        $display("FAIL bit_hold dut=%0d bit=%0d sdo=%b required %b",
                                 w, b, sdo_of(w), stream[b]);
                    end
                end
                @(negedge clk);
            end
        end
        checks++;
        if (done_of(w) !== 1'b1 || sframe_of(w) !== 1'b0 || sdo_of(w) !== 1'b0 || rdy(w) !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle dut=%0d done=%b sframe=%b sdo=%b in_ready=%b required 1/0/0/0",
                     w, done_of(w), sframe_of(w), sdo_of(w), rdy(w));
        end
        @(negedge clk);
        checks++;
        if (rdy(w) !== 1'b1 || done_of(w) !== 1'b0 || sframe_of(w) !== 1'b0) begin
            errors++;
            $display("FAIL idle_return dut=%0d in_ready=%b done=%b sframe=%b required 1/0/0",
                     w, rdy(w), done_of(w), sframe_of(w));
        end
    endtask

    task automatic check_frame(input string name, input logic [11:0] stream,
                               input logic [5:0] xw, input logic [5:0] yw,
                               input logic [11:0] exp_stream, input logic [5:0] exp_x,
                               input logic [5:0] exp_y);
        checks++;
        if (xw !== exp_x) begin
            errors++;
            $display("FAIL %s_x x_word=%b required %b", name, xw, exp_x);
        end
        checks++;
        if (yw !== exp_y) begin
            errors++;
            $display("FAIL %s_y y_word=%b required %b", name, yw, exp_y);
        end
        checks++;
        if (stream !== exp_stream) begin
            errors++;
            $display("FAIL %s_stream stream=%b required %b", name, stream, exp_stream);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b000);
        drive(1, 1'b0, 1'b0, 3'b000);
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (x_a !== 6'd0 || y_a !== 6'd0 || sdo_a !== 1'b0 || sframe_a !== 1'b0 ||
            done_a !== 1'b0 || if_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a x=%b y=%b sdo=%b sframe=%b done=%b rdy=%b required 0/0/0/0/0/1",
                     x_a, y_a, sdo_a, sframe_a, done_a, if_a.in_ready);
        end
        checks++;
        if (x_b !== 6'd0 || y_b !== 6'd0 || sdo_b !== 1'b0 || sframe_b !== 1'b0 ||
            done_b !== 1'b0 || if_b.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b x=%b y=%b sdo=%b sframe=%b done=%b rdy=%b required 0/0/0/0/0/1",
                     x_b, y_b, sdo_b, sframe_b, done_b, if_b.in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_route0();
        logic [11:0] s; logic [5:0] xw, yw; int wt;
        send_frame(0, 1'b0, 3'b101, 1'b0, s, xw, yw, wt);
        check_frame("route0", s, xw, yw, 12'b010000000000, 6'b010000, 6'b000000);
    endtask

    task automatic test_route1();
        logic [11:0] s; logic [5:0] xw, yw; int wt;
        send_frame(0, 1'b1, 3'b110, 1'b0, s, xw, yw, wt);
        check_frame("route1", s, xw, yw, 12'b000000100001, 6'b000000, 6'b100001);
        checks++;
        if (decode(s) !== 3'b110) begin
            errors++;
            $display("FAIL route1_decode o=%b required 110", decode(s));
        end
    endtask

    task automatic test_bit_cycles();
        logic [11:0] s; logic [5:0] xw, yw; int wt;
        send_frame(1, 1'b0, 3'b000, 1'b0, s, xw, yw, wt);
        check_frame("bc3", s, xw, yw, 12'b111000100000, 6'b111000, 6'b100000);
    endtask

    task automatic test_back_to_back();
        logic [11:0] s1, s2; logic [5:0] x1, y1, x2, y2; int w1, w2;
        send_frame(0, 1'b0, 3'b001, 1'b1, s1, x1, y1, w1);
        send_frame(0, 1'b0, 3'b111, 1'b0, s2, x2, y2, w2);
        check_frame("b2b_first", s1, x1, y1, 12'b110000100000, 6'b110000, 6'b100000);
        check_frame("b2b_second", s2, x2, y2, 12'b000000000000, 6'b000000, 6'b000000);
        checks++;
        if (w2 !== 0) begin
            errors++;
            $display("FAIL b2b_bubble extra_wait=%0d required 0", w2);
        end
        @(negedge clk);
        checks++;
        if (sframe_a !== 1'b0 || if_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_extra_accept sframe=%b in_ready=%b required 0/1",
                     sframe_a, if_a.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] s; logic [5:0] xw, yw; int wt;
        int waited;
        drive(0, 1'b1, 1'b0, 3'b101);
        waited = 0;
        while (!if_a.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 3'b000);
        repeat (5) @(negedge clk);
        checks++;
        if (sframe_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_inframe sframe=%b required 1", sframe_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (x_a !== 6'd0 || y_a !== 6'd0 || sdo_a !== 1'b0 || sframe_a !== 1'b0 ||
            done_a !== 1'b0 || if_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset x=%b y=%b sdo=%b sframe=%b done=%b rdy=%b required 0/0/0/0/0/1",
                     x_a, y_a, sdo_a, sframe_a, done_a, if_a.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done_a !== 1'b0 || sframe_a !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_done done=%b sframe=%b required 0/0", done_a, sframe_a);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, 1'b1, 3'b011, 1'b0, s, xw, yw, wt);
        check_frame("after_reset", s, xw, yw, 12'b000000100100, 6'b000000, 6'b100100);
    endtask

    task automatic test_exhaustive();
        logic [11:0] s; logic [5:0] xw, yw; int wt;
        logic [2:0] p;
        logic       r;
        for (int k = 0; k < 16; k++) begin
            r = (k >= 8) ? 1'b1 : 1'b0;
            p = 3'(k);
            send_frame(0, r, p, 1'b0, s, xw, yw, wt);
            checks++;
            if (decode(s) !== p) begin
                errors++;
                $display("FAIL exh_decode route=%b p=%b o=%b required %b", r, p, decode(s), p);
            end
            checks++;
            if ({xw, yw} !== s) begin
                errors++;
                $display("FAIL exh_words route=%b words=%b required stream %b", r, {xw, yw}, s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_route0();
        test_route1();
        test_bit_cycles();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
